cs_auth_responder: RTL

- Charging-station (CS) side of EV-CS mutual authentication; the responder to the EV initiator.
- Accepts M1 from the EV, returns M2 carrying the challenge, nonce and seed, then accepts M3 and verifies the EV's PUF response.
- On success, returns M4 with a token and the CS key share, and exposes the derived session key.
- Sits between the CS message link and the registration database outputs produced at CS-USP registration.

---
 rtl/grid_auth_pkg.sv | 74 +++++++
 rtl/auth_nonce_lfsr.sv | 31 +++
 rtl/cs_auth_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/grid_auth_pkg.sv
// Shared types, fail codes, message layouts and mixing functions for the CS-side
// EV/CS mutual authentication responder.
package grid_auth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK1,
        ST_SEND2,
        ST_WAIT3,
        ST_CHK3,
        ST_SEND4,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [2:0] FAIL_NONE     = 3'd0;
    localparam logic [2:0] FAIL_STALE_M1 = 3'd1;
    localparam logic [2:0] FAIL_PSID     = 3'd2;
    localparam logic [2:0] FAIL_TIMEOUT  = 3'd3;
    localparam logic [2:0] FAIL_STALE_M3 = 3'd4;
    localparam logic [2:0] FAIL_BINDING  = 3'd5;
    localparam logic [2:0] FAIL_RESPONSE = 3'd6;

    // Bit offsets of the 64-bit fields inside the decrypted M1 and M3 words
    localparam int M1_PSID = 192;
    localparam int M1_N1   = 128;
    localparam int M1_PUB  = 64;
    localparam int M1_TS   = 0;

    localparam int M3_PSID = 320;
    localparam int M3_CH   = 256;
    localparam int M3_RS   = 192;
    localparam int M3_CHK  = 128;
    localparam int M3_KI   = 64;
    localparam int M3_TS   = 0;

    localparam logic [63:0] PUF_K = 64'h9E37_79B9_7F4A_7C15;

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] puf(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ PUF_K;
        return y ^ rotl64(y, 13) ^ rotl64(y, 41);
    endfunction

    // Compresses four 64-bit words into one 64-bit digest
    function automatic logic [63:0] hash192(input logic [255:0] m);
        return puf(m[255:192] ^ rotl64(m[191:128], 17) ^ rotl64(m[127:64], 31) ^ rotl64(m[63:0], 47));
    endfunction

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
    endfunction

    function automatic logic [255:0] xor256_k64(input logic [255:0] m, input logic [63:0] k);
        return m ^ {4{k}};
    endfunction

    function automatic logic [319:0] xor320_k64(input logic [319:0] m, input logic [63:0] k);
        return m ^ {5{k}};
    endfunction

    function automatic logic [383:0] xor384_k64(input logic [383:0] m, input logic [63:0] k);
        return m ^ {6{k}};
    endfunction

    function automatic logic [447:0] xor448_k64(input logic [447:0] m, input logic [63:0] k);
        return m ^ {7{k}};
    endfunction

endpackage

// File: rtl/auth_nonce_lfsr.sv
// Nonce generator: 64-bit LFSR that can step zero, one or two positions per clock.
module auth_nonce_lfsr
    import grid_auth_pkg::*;
#(
    parameter logic [63:0] SEED = 64'h3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  adv,
    output logic [63:0] cur,
    output logic [63:0] next
);

    logic [63:0] state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            case (adv)
                2'd1:    state <= lfsr_next(state);
                2'd2:    state <= lfsr_next(lfsr_next(state));
                default: state <= state;
            endcase
        end
    end

    assign cur  = state;
    assign next = lfsr_next(state);

endmodule

// File: rtl/cs_auth_responder.sv
// Charging-station responder: answers EV M1 with M2, verifies the PUF response in M3
// and returns M4 plus the derived session key on success.
module cs_auth_responder
    import grid_auth_pkg::*;
#(
    parameter logic [63:0] ACCEPTABLE_DELAY = 64'd10,
    parameter int          TIMEOUT_CYCLES   = 64,
    parameter logic [63:0] LFSR_SEED        = 64'h3,
    parameter logic [63:0] CS_ID            = 64'hDDDD_DDDD_DDDD_DDDD,
    parameter logic [63:0] T_VALID          = 64'd60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  now_ts,
    input  logic [63:0]  cs_pub_key,
    input  logic [63:0]  cs_prv_key,
    input  logic [63:0]  ev_pub_key,
    input  logic [63:0]  reg_psid,
    input  logic [63:0]  reg_ch,
    input  logic [63:0]  reg_rs,
    input  logic         m1_valid,
    output logic         m1_ready,
    input  logic [255:0] m1_data,
    output logic         m2_valid,
    input  logic         m2_ready,
    output logic [319:0] m2_data,
    input  logic         m3_valid,
    output logic         m3_ready,
    input  logic [383:0] m3_data,
    output logic         m4_valid,
    input  logic         m4_ready,
    output logic [447:0] m4_data,
    output logic         auth_ok,
    output logic         auth_fail,
    output logic [2:0]   fail_code,
    output logic [63:0]  session_key
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    logic [TW-1:0] timer;

    logic [63:0]  sess_psid, sess_n1, sess_ts1, sess_ch, sess_n2, sess_seed, sess_key;
    logic [383:0] m3_held;
    logic [255:0] m1_plain;
    logic [383:0] m3_plain;
    logic         unused_pub;

    logic [1:0]   lfsr_adv;
    logic [63:0]  nonce_cur, nonce_next;

    logic         m1_fire, m2_fire, m3_fire, m4_fire;
    logic         stale1, stale3, chk1_ok, chk3_ok, bind_ok;
    logic [63:0]  k_k, k_ki, rs_k, tk_i;

    assign m1_plain   = xor256_k64(m1_data, cs_pub_key);
    assign m3_plain   = xor384_k64(m3_data, cs_pub_key);
    assign unused_pub = ^m1_plain[M1_PUB +: 64];

    assign m1_fire = m1_valid && m1_ready;
    assign m2_fire = m2_valid && m2_ready;
    assign m3_fire = m3_valid && m3_ready;
    assign m4_fire = m4_valid && m4_ready;

    // Freshness uses wrapping subtraction so a counter rollover is not flagged stale
    assign stale1  = (now_ts - sess_ts1) > ACCEPTABLE_DELAY;
    assign stale3  = (now_ts - m3_held[M3_TS +: 64]) > ACCEPTABLE_DELAY;
    assign bind_ok = (m3_held[M3_PSID +: 64] == sess_psid) && (m3_held[M3_CH +: 64] == sess_ch);
    assign chk1_ok = (state == ST_CHK1) && !stale1 && (sess_psid == reg_psid);
    assign chk3_ok = (state == ST_CHK3) && !stale3 && bind_ok && (m3_held[M3_RS +: 64] == reg_rs);

    assign k_k  = puf(sess_seed ^ cs_prv_key);
    assign k_ki = hash192({m3_held[M3_KI +: 64], k_k, sess_n1, sess_n2});
    assign rs_k = puf(m3_held[M3_CHK +: 64]);
    assign tk_i = hash192({sess_psid, T_VALID, reg_rs, CS_ID});

    assign lfsr_adv = chk1_ok ? 2'd2 : (chk3_ok ? 2'd1 : 2'd0);

    auth_nonce_lfsr #(.SEED(LFSR_SEED)) u_nonce (
        .clk  (clk),
        .rst  (rst),
        .adv  (lfsr_adv),
        .cur  (nonce_cur),
        .next (nonce_next)
    );

    always_ff @(posedge clk) begin
        if (m1_fire) begin
            sess_psid <= m1_plain[M1_PSID +: 64];
            sess_n1   <= m1_plain[M1_N1 +: 64];
            sess_ts1  <= m1_plain[M1_TS +: 64];
        end
        if (chk1_ok) begin
            sess_ch   <= reg_ch;
            sess_n2   <= nonce_cur;
            sess_seed <= nonce_next;
        end
        if (m3_fire) begin
            m3_held <= m3_plain;
        end
        if (chk3_ok) begin
            sess_key <= k_ki;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            m1_ready    <= 1'b0;
            m2_valid    <= 1'b0;
            m2_data     <= '0;
            m3_ready    <= 1'b0;
            m4_valid    <= 1'b0;
            m4_data     <= '0;
            auth_ok     <= 1'b0;
            auth_fail   <= 1'b0;
            fail_code   <= FAIL_NONE;
            session_key <= '0;
        end else begin
            auth_ok   <= 1'b0;
            auth_fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    m1_ready <= 1'b1;
                    if (m1_fire) begin
                        m1_ready    <= 1'b0;
                        fail_code   <= FAIL_NONE;
                        session_key <= '0;
                        state       <= ST_CHK1;
                    end
                end
                ST_CHK1: begin
                    if (stale1) begin
                        fail_code <= FAIL_STALE_M1;
                        auth_fail <= 1'b1;
                        state     <= ST_FAIL;
                    end else if (sess_psid != reg_psid) begin
                        fail_code <= FAIL_PSID;
                        auth_fail <= 1'b1;
                        state     <= ST_FAIL;
                    end else begin
                        m2_data  <= xor320_k64({CS_ID, reg_ch, nonce_cur, nonce_next, now_ts}, ev_pub_key);
                        m2_valid <= 1'b1;
                        state    <= ST_SEND2;
                    end
                end
                ST_SEND2: begin
                    if (m2_fire) begin
                        m2_valid <= 1'b0;
                        m3_ready <= 1'b1;
                        timer    <= '0;
                        state    <= ST_WAIT3;
                    end
                end
                ST_WAIT3: begin
                    // A transfer in the final allowed cycle takes priority over expiry
                    if (m3_fire) begin
                        m3_ready <= 1'b0;
                        state    <= ST_CHK3;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        m3_ready  <= 1'b0;
                        fail_code <= FAIL_TIMEOUT;
                        auth_fail <= 1'b1;
                        state     <= ST_FAIL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CHK3: begin
                    if (stale3) begin
                        fail_code <= FAIL_STALE_M3;
                        auth_fail <= 1'b1;
                        state     <= ST_FAIL;
                    end else if (!bind_ok) begin
                        fail_code <= FAIL_BINDING;
                        auth_fail <= 1'b1;
                        state     <= ST_FAIL;
                    end else if (m3_held[M3_RS +: 64] != reg_rs) begin
                        fail_code <= FAIL_RESPONSE;
                        auth_fail <= 1'b1;
                        state     <= ST_FAIL;
                    end else begin
                        m4_data  <= xor448_k64({CS_ID, m3_held[M3_CHK +: 64], nonce_cur, rs_k, tk_i, k_k, now_ts}, k_ki);
                        m4_valid <= 1'b1;
                        state    <= ST_SEND4;
                    end
                end
                ST_SEND4: begin
                    if (m4_fire) begin
                        m4_valid    <= 1'b0;
                        auth_ok     <= 1'b1;
                        session_key <= sess_key;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_FAIL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
